// File: rtl/if0_fetch_pc_gen.sv
// if0_fetch_pc_gen
// -----------------------------------------------------------------------------
// Fetch-PC generator for IF stage 0. It holds the fetch PC and presents an
// aligned block of FETCH_WIDTH instruction slots. Each cycle it picks the next
// PC from, in priority order: backend redirect, IF3 redirect, pause, pending
// delay slot, next-line-predictor taken branch, or the sequential block.
//
// Parameters
//   FETCH_WIDTH     instructions per fetch block (power of two, >= 1)
//   RESET_PC        PC loaded on reset
//   HAS_DELAY_SLOT  1: the slot after a taken branch is fetched before the jump
//   EPOCH_W         redirect epoch counter width
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   pause                  hold PC and all state (redirects still apply)
//   bk_redirect_valid/pc   backend redirect request / target
//   bk_ready               always 1
//   if3_redirect_valid/pc  IF3 redirect request / target
//   nlp_valid/taken        per-slot NLP hit / taken prediction for current pc
//   nlp_target             per-slot targets, slot i at [32i+31:32i]
//   pc                     current fetch PC (registered)
//   slot_pc                per-slot PCs of the aligned block
//   slot_mask              slots that belong to this fetch (combinational)
//   only_ds                block exists only to fetch a delay slot
//   epoch                  redirect epoch, +1 per redirect cycle
// -----------------------------------------------------------------------------
module if0_fetch_pc_gen #(
    parameter int          FETCH_WIDTH    = 2,
    parameter logic [31:0] RESET_PC       = 32'hBFC0_0000,
    parameter bit          HAS_DELAY_SLOT = 1'b1,
    parameter int          EPOCH_W        = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pause,
    input  logic                      bk_redirect_valid,
    input  logic [31:0]               bk_redirect_pc,
    output logic                      bk_ready,
    input  logic                      if3_redirect_valid,
    input  logic [31:0]               if3_redirect_pc,
    input  logic [FETCH_WIDTH-1:0]    nlp_valid,
    input  logic [FETCH_WIDTH-1:0]    nlp_taken,
    input  logic [32*FETCH_WIDTH-1:0] nlp_target,
    output logic [31:0]               pc,
    output logic [32*FETCH_WIDTH-1:0] slot_pc,
    output logic [FETCH_WIDTH-1:0]    slot_mask,
    output logic                      only_ds,
    output logic [EPOCH_W-1:0]        epoch
);

    localparam int W  = FETCH_WIDTH;
    localparam int L  = (W > 1) ? $clog2(W) : 0;
    // Slot-index width; kept at least 1 bit so W=1 still has a legal vector.
    localparam int IW = (L > 0) ? L : 1;
    localparam logic [31:0] BLK_BYTES = 32'(4 * W);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               ds_pend;
    logic [31:0]        ds_target;

    logic [31:0]        pc_nx;
    logic               ds_pend_nx;
    logic [31:0]        ds_target_nx;
    logic [EPOCH_W-1:0] epoch_nx;

    // ------------------------------------------------------------------
    // Derived block geometry
    // ------------------------------------------------------------------
    logic [IW-1:0] off;
    logic [31:0]   aligned;
    logic [31:0]   seq;

    // Mask arithmetic instead of part-selects so W=1 (L=0) needs no
    // special-casing: the offset collapses to zero.
    assign off     = IW'((pc >> 2) & 32'(W - 1));
    assign aligned = pc & ~(BLK_BYTES - 32'd1);
    assign seq     = aligned + BLK_BYTES;

    assign bk_ready = 1'b1;
    assign only_ds  = ds_pend;

    for (genvar i = 0; i < W; i++) begin : g_slot_pc
        assign slot_pc[32*i +: 32] = aligned | 32'(i * 4);
    end

    // ------------------------------------------------------------------
    // Branch selection: lowest eligible slot at or above the entry offset.
    // A pending delay-slot block never redirects on its own predictions.
    // ------------------------------------------------------------------
    logic [W-1:0]  elig;
    logic          taken;
    logic [IW-1:0] k;
    logic [31:0]   target_k;

    always_comb begin
        elig  = '0;
        taken = 1'b0;
        k     = '0;
        for (int i = W - 1; i >= 0; i--) begin
            elig[i] = (i >= int'(off)) && nlp_valid[i] && nlp_taken[i] && !ds_pend;
            if (elig[i]) begin
                taken = 1'b1;
                k     = IW'(i);
            end
        end
    end

    assign target_k = nlp_target[32*int'(k) +: 32];

    // Branch sits in the last slot and its delay slot spills into the next
    // block: fetch that block first, jump afterwards.
    logic last_slot_ds;
    assign last_slot_ds = taken && HAS_DELAY_SLOT && (int'(k) == W - 1);

    // ------------------------------------------------------------------
    // Slot mask
    // ------------------------------------------------------------------
    int lim;

    always_comb begin
        lim = W - 1;
        if (taken) begin
            if (HAS_DELAY_SLOT)
                lim = (int'(k) < W - 1) ? int'(k) + 1 : W - 1;
            else
                lim = int'(k);
        end
        slot_mask = '0;
        if (ds_pend) begin
            // Delay-slot block: the delay slot is always slot 0 of seq.
            slot_mask[0] = 1'b1;
        end else begin
            for (int i = 0; i < W; i++)
                slot_mask[i] = (i >= int'(off)) && (i <= lim);
        end
    end

    // ------------------------------------------------------------------
    // Next-state selection
    // ------------------------------------------------------------------
    always_comb begin
        pc_nx        = pc;
        ds_pend_nx   = ds_pend;
        ds_target_nx = ds_target;
        epoch_nx     = epoch;
        if (bk_redirect_valid) begin
            // Redirects win over pause and drop any pending delay slot.
            pc_nx      = bk_redirect_pc & ~32'd3;
            ds_pend_nx = 1'b0;
            epoch_nx   = epoch + 1'b1;
        end else if (if3_redirect_valid) begin
            pc_nx      = if3_redirect_pc & ~32'd3;
            ds_pend_nx = 1'b0;
            epoch_nx   = epoch + 1'b1;
        end else if (!pause) begin
            if (ds_pend) begin
                pc_nx      = ds_target;
                ds_pend_nx = 1'b0;
            end else if (last_slot_ds) begin
                pc_nx        = seq;
                ds_pend_nx   = 1'b1;
                ds_target_nx = target_k;
            end else if (taken) begin
                pc_nx = target_k;
            end else begin
                pc_nx = seq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            ds_pend   <= 1'b0;
            ds_target <= '0;
            epoch     <= '0;
        end else begin
            pc        <= pc_nx;
            ds_pend   <= ds_pend_nx;
            ds_target <= ds_target_nx;
            epoch     <= epoch_nx;
        end
    end

endmodule
